fp8_pack_scheduler: RTL and testbench

- Sequences a burst of LANES FP12 accumulator results from the MAC array through one shared FP12→FP8 rounding stage, one lane per cycle.
- Packs four FP8 results per 32-bit word and streams the words to the activation/writeback path with a valid/ready handshake.
- Keeps a saturating count of results that rounded to infinity.

---
 rtl/fp8_pack_scheduler.sv | 144 ++++++++++++++
 tb/tb_fp8_pack_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp8_pack_scheduler.sv
// Serialises a LANES-wide FP12 burst through one FP12->FP8 rounder and packs
// four results per 32-bit output word. Optional build macro: FP8_SATURATE_EN.

module fp8_pack_scheduler_rnd (
  input  logic [11:0] i_fp12,
  output logic [7:0]  o_fp8,
  output logic        o_inf
);
  logic       w_s;
  logic [3:0] w_e;
  logic [3:0] w_t;

  assign w_s = i_fp12[11];
  assign w_e = i_fp12[10:7];
  // Round half up on the top three mantissa bits; w_t[3] flags mantissa carry-out.
  assign w_t = {1'b0, i_fp12[6:4]} + {3'b000, i_fp12[3]};

  always_comb begin
    if (w_e == 4'hF)
      o_fp8 = {w_s, 4'hF, 3'b000};
    else if (w_t[3] && (w_e == 4'hE))
`ifdef FP8_SATURATE_EN
      o_fp8 = {w_s, 4'hE, 3'b111};
`else
      o_fp8 = {w_s, 4'hF, 3'b000};
`endif
    else if (w_t[3])
      o_fp8 = {w_s, w_e + 4'd1, 3'b000};
    else
      o_fp8 = {w_s, w_e, w_t[2:0]};
  end

  assign o_inf = (o_fp8[6:3] == 4'hF);
endmodule

module fp8_pack_scheduler #(
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*12-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_last,
  output logic               busy,
  output logic [CNT_W-1:0]   inf_count,
  input  logic               cnt_clear
);
  localparam int IW = $clog2(LANES + 1);
  localparam int LW = $clog2(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES);

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_idx;
  logic [LANES-1:0][11:0] r_buf;
  logic [3:0][7:0]        r_pack;

  logic [LW-1:0]          w_sel;
  logic [11:0]            w_lane;
  logic [7:0]             w_fp8;
  logic                   w_inf;
  logic [3:0][7:0]        w_word;
  logic [IW-1:0]          w_idx_nx;

  assign w_sel    = r_idx[LW-1:0];
  assign w_lane   = r_buf[w_sel];
  assign w_idx_nx = r_idx + 1'b1;

  fp8_pack_scheduler_rnd u_rnd (
    .i_fp12 (w_lane),
    .o_fp8  (w_fp8),
    .o_inf  (w_inf)
  );

  // Word as it stands once the current lane's byte is merged in.
  always_comb begin
    w_word             = r_pack;
    w_word[r_idx[1:0]] = w_fp8;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_buf     <= '0;
      r_pack    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_buf    <= in_data;
            r_state  <= CONV;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CONV: begin
          r_pack <= w_word;
          r_idx  <= w_idx_nx;
          if (r_idx[1:0] == 2'd3) begin
            r_state   <= EMIT;
            out_valid <= 1'b1;
            out_data  <= w_word;
            out_last  <= (w_idx_nx == LAST_IDX);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state  <= IDLE;
              r_idx    <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              r_state <= CONV;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Clear beats increment; count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear)
      inf_count <= '0;
    else if ((r_state == CONV) && w_inf && (inf_count != {CNT_W{1'b1}}))
      inf_count <= inf_count + 1'b1;
  end
endmodule

// File: tb/tb_fp8_pack_scheduler.sv
// Directed bench for fp8_pack_scheduler: scoreboard of expected packed words,
// latency, stall, busy-rejection, mid-burst reset and counter saturation.
module tb_fp8_pack_scheduler;
  localparam int LANES = 8;
  localparam int CW    = 6;
`ifdef FP8_SATURATE_EN
  localparam logic [31:0] T2_W0  = 32'h00F87730;
  localparam int          T2_INF = 1;
`else
  localparam logic [31:0] T2_W0  = 32'h00F87830;
  localparam int          T2_INF = 2;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy, cnt_clear;
  logic [LANES*12-1:0] in_data;
  logic [31:0]         out_data;
  logic [CW-1:0]       inf_count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  logic [32:0] sb[$];
  logic [LANES-1:0][11:0] lanes;

  always #5 clk = ~clk;

  fp8_pack_scheduler #(.LANES(LANES), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .inf_count (inf_count),
    .cnt_clear (cnt_clear)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in_ready"},  in_ready,  1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"},  out_data,  0);
    chk({tag, " out_last"},  out_last,  0);
    chk({tag, " busy"},      busy,      0);
    chk({tag, " inf_count"}, inf_count, 0);
  endtask

  // Called at the negedge just after the acceptance/handshake edge.
  task automatic get_word(input string tag, input int exp_lat);
    int lat;
    logic [32:0] e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    e = (sb.size() > 0) ? sb.pop_front() : 33'h0;
    chk({tag, " data"}, out_data, e[31:0]);
    chk({tag, " last"}, out_last, e[32]);
  endtask

  task automatic start(input logic [LANES*12-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run2(input string tag, input logic [LANES*12-1:0] d,
                      input logic [31:0] w0, input logic [31:0] w1);
    sb.push_back({1'b0, w0});
    sb.push_back({1'b1, w1});
    start(d);
    get_word({tag, " w0"}, 4);
    @(negedge clk);
    get_word({tag, " w1"}, 4);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Uniform burst: 0x3C8 rounds to 0x3D
    for (int k = 0; k < LANES; k++) lanes[k] = 12'h3C8;
    run2("t1", lanes, 32'h3D3D3D3D, 32'h3D3D3D3D);
    chk("t1 in_ready", in_ready, 1);
    chk("t1 busy", busy, 0);
    chk("t1 inf", inf_count, 0);

    // Carry into exponent, overflow at e=14, e=15, zero
    lanes[0] = 12'h2F8; lanes[1] = 12'h778; lanes[2] = 12'hF80; lanes[3] = 12'h000;
    run2("t2", lanes, T2_W0, 32'h3D3D3D3D);
    chk("t2 inf", inf_count, T2_INF);

    // Stall on word 0 while a second burst waits on in_valid
    for (int k = 0; k < LANES; k++) lanes[k] = 12'((k + 1) * 128 + 16);
    out_ready = 1'b0;
    sb.push_back({1'b0, 32'h21191109});
    sb.push_back({1'b1, 32'h41393129});
    start(lanes);
    get_word("t3 w0", 4);
    for (int k = 0; k < LANES; k++) lanes[k] = 12'h3C8;
    in_data  = lanes;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t3 stall valid", out_valid, 1);
      chk("t3 stall data", out_data, 32'h21191109);
      chk("t3 stall in_ready", in_ready, 0);
      chk("t3 stall inf", inf_count, T2_INF);
    end
    chk("t3 busy", busy, 1);
    out_ready = 1'b1;
    @(negedge clk);
    get_word("t3 w1", 4);
    @(negedge clk);
    chk("t4 in_ready idle", in_ready, 1);
    sb.push_back({1'b0, 32'h3D3D3D3D});
    sb.push_back({1'b1, 32'h3D3D3D3D});
    @(negedge clk);
    in_valid = 1'b0;
    get_word("t4 w0", 4);
    @(negedge clk);
    get_word("t4 w1", 4);
    @(negedge clk);

    // Reset during CONV of word 1
    sb.push_back({1'b0, 32'h3D3D3D3D});
    start(lanes);
    get_word("t5 w0", 4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("t5 reset");
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t5 no word", seen, 0);

    // Saturation: 64 Inf lanes into a 6-bit counter
    for (int k = 0; k < LANES; k++) lanes[k] = 12'hF80;
    for (int b = 0; b < 8; b++) run2("t6", lanes, 32'hF8F8F8F8, 32'hF8F8F8F8);
    chk("t6 sat", inf_count, 63);
    run2("t6b", lanes, 32'hF8F8F8F8, 32'hF8F8F8F8);
    chk("t6 hold", inf_count, 63);

    // Clear coincides with the first Inf lane's conversion
    sb.push_back({1'b0, 32'hF8F8F8F8});
    sb.push_back({1'b1, 32'hF8F8F8F8});
    in_data  = lanes;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    chk("t6 clear", inf_count, 0);
    get_word("t6c w0", 3);
    @(negedge clk);
    get_word("t6c w1", 4);
    @(negedge clk);
    chk("t6 after clear", inf_count, 7);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
